// File: rtl/dsc_pkg.sv
// Shared types and defaults for the path output stream (saida_caminho).
// ADDR_WIDTH falls back to 8 when the build does not define it.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package dsc_pkg;

  localparam int MAX_CAMINHO_DEF = 256;

  typedef enum logic [1:0] {
    OCIOSO,
    CARREGANDO,
    ENVIANDO
  } sc_estado_t;

endpackage

// File: rtl/pilha_caminho.sv
// Path node storage: register array with a write port and a registered read
// pointer that is loaded at stream start and stepped up or down per transfer.
module pilha_caminho #(
  parameter int ADDR_WIDTH  = 8,
  parameter int MAX_CAMINHO = 256,
  parameter int PTR_W       = $clog2(MAX_CAMINHO)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_idx,
  input  logic [ADDR_WIDTH-1:0] wr_data,
  input  logic                  rd_load,
  input  logic [PTR_W-1:0]      rd_ini,
  input  logic                  rd_step,
  input  logic                  rd_desce,
  output logic [ADDR_WIDTH-1:0] rd_data
);

  logic [ADDR_WIDTH-1:0] mem [MAX_CAMINHO];
  logic [PTR_W-1:0]      rd_ptr;

  // Contents are fully rewritten before being read, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (rd_load) begin
      rd_ptr <= rd_ini;
    end else if (rd_step) begin
      rd_ptr <= rd_desce ? rd_ptr - PTR_W'(1) : rd_ptr + PTR_W'(1);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/saida_caminho.sv
// Collects path nodes from the predecessor walk and streams them out with a
// valid/ready handshake. SAIDA_CAMINHO_INVERTER_EN selects LIFO (source first).
//
// state      | meaning
// OCIOSO     | idle, waiting for the first node of a new path
// CARREGANDO | storing nodes until the walk signals pronto
// ENVIANDO   | streaming stored nodes downstream
module saida_caminho
  import dsc_pkg::*;
#(
  parameter int ADDR_WIDTH  = `ADDR_WIDTH,
  parameter int MAX_CAMINHO = MAX_CAMINHO_DEF,
  parameter int TAM_WIDTH   = $clog2(MAX_CAMINHO + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] sc_addr_in,
  input  logic                  sc_valid_in,
  input  logic                  sc_pronto_in,
  input  logic                  sc_ready_in,
  output logic [ADDR_WIDTH-1:0] sc_addr_out,
  output logic                  sc_valid_out,
  output logic                  sc_last_out,
  output logic [TAM_WIDTH-1:0]  sc_tamanho_out,
  output logic                  sc_ocupado_out,
  output logic                  sc_erro_out
);

  localparam int PTR_W = $clog2(MAX_CAMINHO);

  sc_estado_t            estado, estado_prox;
  logic [TAM_WIDTH-1:0]  cnt, cnt_prox, restantes, tamanho;
  logic                  erro;
  logic                  cheio, push, rd_load, rd_step, rd_desce;
  logic [PTR_W-1:0]      wr_idx, rd_ini;
  logic [ADDR_WIDTH-1:0] rd_data;

  assign cheio  = (cnt == TAM_WIDTH'(MAX_CAMINHO));
  assign wr_idx = (estado == OCIOSO) ? '0 : cnt[PTR_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    cnt_prox    = cnt;
    push        = 1'b0;
    rd_load     = 1'b0;
    rd_step     = 1'b0;
    case (estado)
      OCIOSO: begin
        push     = sc_valid_in;
        cnt_prox = sc_valid_in ? TAM_WIDTH'(1) : '0;
        if (sc_valid_in && sc_pronto_in) begin
          estado_prox = ENVIANDO;
          rd_load     = 1'b1;
        end else if (sc_valid_in) begin
          estado_prox = CARREGANDO;
        end
      end
      CARREGANDO: begin
        push     = sc_valid_in && !cheio;
        cnt_prox = cnt + TAM_WIDTH'(push);
        if (sc_pronto_in) begin
          estado_prox = ENVIANDO;
          rd_load     = 1'b1;
        end
      end
      ENVIANDO: begin
        if (sc_ready_in) begin
          if (restantes == TAM_WIDTH'(1)) estado_prox = OCIOSO;
          else                            rd_step     = 1'b1;
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

`ifdef SAIDA_CAMINHO_INVERTER_EN
  assign rd_desce = 1'b1;
  assign rd_ini   = PTR_W'(cnt_prox - TAM_WIDTH'(1));
`else
  assign rd_desce = 1'b0;
  assign rd_ini   = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      restantes <= '0;
      tamanho   <= '0;
      erro      <= 1'b0;
    end else begin
      cnt <= cnt_prox;
      if (estado == OCIOSO && sc_valid_in)                erro <= 1'b0;
      if (estado == CARREGANDO && sc_valid_in && cheio)   erro <= 1'b1;
      if (estado == ENVIANDO && sc_valid_in)              erro <= 1'b1;
      if (rd_load) begin
        tamanho   <= cnt_prox;
        restantes <= cnt_prox;
      end else if (estado == OCIOSO && sc_pronto_in) begin
        tamanho <= '0;
      end
      if (rd_step) restantes <= restantes - TAM_WIDTH'(1);
    end
  end

  pilha_caminho #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_CAMINHO(MAX_CAMINHO),
    .PTR_W      (PTR_W)
  ) u_pilha (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_idx  (wr_idx),
    .wr_data (sc_addr_in),
    .rd_load (rd_load),
    .rd_ini  (rd_ini),
    .rd_step (rd_step),
    .rd_desce(rd_desce),
    .rd_data (rd_data)
  );

  // Output word is gated so it reads zero whenever nothing is offered.
  assign sc_valid_out   = (estado == ENVIANDO);
  assign sc_addr_out    = sc_valid_out ? rd_data : '0;
  assign sc_last_out    = sc_valid_out && (restantes == TAM_WIDTH'(1));
  assign sc_tamanho_out = tamanho;
  assign sc_ocupado_out = (estado != OCIOSO);
  assign sc_erro_out    = erro;

endmodule

// File: tb/tb_saida_caminho.sv
// Directed bench for saida_caminho: default depth instance plus a depth-4
// instance for overflow; expected order follows SAIDA_CAMINHO_INVERTER_EN.
module tb_saida_caminho;

  localparam int AW = 8;
`ifdef SAIDA_CAMINHO_INVERTER_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic          valid_in = 1'b0, pronto_in = 1'b0, ready_in = 1'b0;
  logic          valid4 = 1'b0, pronto4 = 1'b0;

  logic [AW-1:0] addr_out, addr4;
  logic          valid_out, last_out, ocupado, erro;
  logic          valid_o4, last4, ocup4, erro4;
  logic [8:0]    tam_out;
  logic [2:0]    tam4;

  int errors = 0;
  int checks = 0;
  logic [AW-1:0] caminho [8];

  always #5 clk = ~clk;

  saida_caminho #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .sc_addr_in(addr_in), .sc_valid_in(valid_in),
    .sc_pronto_in(pronto_in), .sc_ready_in(ready_in), .sc_addr_out(addr_out),
    .sc_valid_out(valid_out), .sc_last_out(last_out), .sc_tamanho_out(tam_out),
    .sc_ocupado_out(ocupado), .sc_erro_out(erro)
  );

  saida_caminho #(.ADDR_WIDTH(AW), .MAX_CAMINHO(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sc_addr_in(addr_in), .sc_valid_in(valid4),
    .sc_pronto_in(pronto4), .sc_ready_in(ready_in), .sc_addr_out(addr4),
    .sc_valid_out(valid_o4), .sc_last_out(last4), .sc_tamanho_out(tam4),
    .sc_ocupado_out(ocup4), .sc_erro_out(erro4)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_path(input int n, input bit with_pronto);
    for (int i = 0; i < n; i++) begin
      valid_in  = 1'b1;
      addr_in   = caminho[i];
      pronto_in = with_pronto && (i == n - 1);
      tick;
    end
    valid_in  = 1'b0;
    pronto_in = 1'b0;
    if (!with_pronto) begin
      pronto_in = 1'b1;
      tick;
      pronto_in = 1'b0;
    end
  endtask

  task automatic receive(input int n, input bit toggle, input string tag);
    int k = 0;
    int cyc = 0;
    bit hold_f = 1'b0;
    logic [AW-1:0] hold = '0;
    while (k < n && cyc < 200) begin
      ready_in = toggle ? (cyc % 3 == 0) : 1'b1;
      if (hold_f) begin
        check({tag, "_stable"}, int'(addr_out), int'(hold));
        hold_f = 1'b0;
      end
      if (valid_out && ready_in) begin
        check({tag, "_addr"}, int'(addr_out), int'(caminho[INV ? n - 1 - k : k]));
        check({tag, "_last"}, int'(last_out), int'(k == n - 1));
        k++;
      end else if (valid_out) begin
        hold   = addr_out;
        hold_f = 1'b1;
      end else begin
        check({tag, "_valid"}, int'(valid_out), 1);
      end
      tick;
      cyc++;
    end
    check({tag, "_count"}, k, n);
    check({tag, "_idle"}, int'(valid_out), 0);
    check({tag, "_ocupado"}, int'(ocupado), 0);
  endtask

  initial begin
    // reset
    tick;
    tick;
    check("rst_valid", int'(valid_out), 0);
    check("rst_last", int'(last_out), 0);
    check("rst_tam", int'(tam_out), 0);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_erro", int'(erro), 0);
    check("rst_addr", int'(addr_out), 0);
    rst_n    = 1'b1;
    ready_in = 1'b1;
    tick;

    // 5-node path, ready always high
    caminho[0] = 8'd42; caminho[1] = 8'd17; caminho[2] = 8'd9;
    caminho[3] = 8'd8;  caminho[4] = 8'd3;
    valid_in = 1'b1; addr_in = caminho[0];
    tick;
    check("t1_ocupado_load", int'(ocupado), 1);
    check("t1_valid_load", int'(valid_out), 0);
    valid_in = 1'b0;
    for (int i = 1; i < 5; i++) begin
      valid_in = 1'b1; addr_in = caminho[i];
      tick;
    end
    valid_in = 1'b0; pronto_in = 1'b1;
    tick;
    pronto_in = 1'b0;
    check("t1_valid_first", int'(valid_out), 1);
    check("t1_tam", int'(tam_out), 5);
    receive(5, 1'b0, "t1");

    // same path, ready pattern 1,0,0,...
    push_path(5, 1'b0);
    check("t2_tam", int'(tam_out), 5);
    receive(5, 1'b1, "t2");

    // pronto with empty path
    ready_in = 1'b1;
    pronto_in = 1'b1;
    tick;
    pronto_in = 1'b0;
    check("t3_tam", int'(tam_out), 0);
    for (int i = 0; i < 3; i++) begin
      check("t3_valid", int'(valid_out), 0);
      check("t3_ocupado", int'(ocupado), 0);
      tick;
    end

    // reset mid-stream after two transfers, then a fresh 3-node path
    caminho[0] = 8'd11; caminho[1] = 8'd22; caminho[2] = 8'd33; caminho[3] = 8'd44;
    push_path(4, 1'b0);
    tick;
    tick;
    check("t4_addr_third", int'(addr_out), int'(INV ? caminho[1] : caminho[2]));
    rst_n = 1'b0;
    tick;
    check("t4_rst_valid", int'(valid_out), 0);
    check("t4_rst_last", int'(last_out), 0);
    check("t4_rst_tam", int'(tam_out), 0);
    check("t4_rst_ocupado", int'(ocupado), 0);
    check("t4_rst_erro", int'(erro), 0);
    check("t4_rst_addr", int'(addr_out), 0);
    rst_n = 1'b1;
    caminho[0] = 8'd7; caminho[1] = 8'd8; caminho[2] = 8'd9;
    push_path(3, 1'b0);
    check("t4_tam", int'(tam_out), 3);
    receive(3, 1'b0, "t4");

    // last push with pronto, then a push while streaming
    caminho[0] = 8'd100; caminho[1] = 8'd101; caminho[2] = 8'd102;
    push_path(3, 1'b1);
    check("t5_valid_first", int'(valid_out), 1);
    check("t5_tam", int'(tam_out), 3);
    check("t5_erro_before", int'(erro), 0);
    ready_in = 1'b0;
    valid_in = 1'b1; addr_in = 8'd200;
    tick;
    valid_in = 1'b0;
    check("t5_erro", int'(erro), 1);
    check("t5_tam_after", int'(tam_out), 3);
    check("t5_addr_held", int'(addr_out), int'(INV ? caminho[2] : caminho[0]));
    receive(3, 1'b0, "t5");

    // overflow on the depth-4 instance
    ready_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid4 = 1'b1; addr_in = AW'(i + 1);
      tick;
    end
    valid4 = 1'b0; pronto4 = 1'b1;
    tick;
    pronto4 = 1'b0;
    check("t6_erro", int'(erro4), 1);
    check("t6_tam", int'(tam4), 4);
    for (int k = 0; k < 4; k++) begin
      check("t6_valid", int'(valid_o4), 1);
      check("t6_addr", int'(addr4), INV ? 4 - k : k + 1);
      check("t6_last", int'(last4), int'(k == 3));
      tick;
    end
    check("t6_idle", int'(valid_o4), 0);
    check("t6_erro_sticky", int'(erro4), 1);
    valid4 = 1'b1; addr_in = 8'd55;
    tick;
    valid4 = 1'b0;
    check("t6_erro_clear", int'(erro4), 0);
    check("t6_ocupado", int'(ocup4), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
